// File: rtl/ga20_pcm_if.sv
// ga20_pcm_if: sample ROM fetch port of the GA20 PCM player.
//
// Handshake: the player raises rom_req with rom_addr and holds both
// steady until the ROM answers with a single-cycle rom_ack. rom_data is
// valid in the rom_ack cycle only. rom_req drops in the cycle after the ack.
//
// Signals:
//   rom_req   player -> ROM   fetch request, held until ack
//   rom_addr  player -> ROM   byte address, stable while rom_req=1
//   rom_ack   ROM -> player   one-cycle acknowledge
//   rom_data  ROM -> player   sample byte, valid with rom_ack
//
// Modports: master = player side, slave = ROM side.
interface ga20_pcm_if #(
  parameter int ROM_AW = 20
);
  logic              rom_req;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_ack;
  logic [7:0]        rom_data;

  modport master (output rom_req, output rom_addr, input rom_ack, input rom_data);
  modport slave  (input rom_req, input rom_addr, output rom_ack, output rom_data);
endinterface

// File: rtl/ga20_pcm.sv
// ga20_pcm: four-channel 8-bit PCM sample player (GA20 compatible).
//
// The sound CPU programs eight registers per channel through a 32-entry
// window (ch = addr[4:3], reg = addr[2:0]). Each ce pulse is one playback
// tick: a scheduler walks channels 0..3, steps each playing channel's rate
// counter, fetches a new byte from the sample ROM when its position moved,
// and finally mixes the four channels into a saturated signed 16-bit sample.
//
// Ports:
//   clk_sys, reset        clock, synchronous active-high reset
//   ce                    playback tick strobe
//   cs, wr, addr, din     register write bus (wr qualified by cs)
//   dout                  register read data, combinational from addr
//   rom                   sample ROM fetch port (ga20_pcm_if.master)
//   mute[3:0]             per-channel mix mute (only with GA20_CH_MUTE_EN)
//   sample                signed mixed output, updated once per tick
//   busy                  scheduler working or a tick is pending
//
// Build option: define GA20_CH_MUTE_EN to add the mute input.
module ga20_pcm #(
  parameter int ROM_AW    = 20,
  parameter int OUT_SHIFT = 0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce,
  input  logic        cs,
  input  logic        wr,
  input  logic [4:0]  addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  ga20_pcm_if.master  rom,
`ifdef GA20_CH_MUTE_EN
  input  logic [3:0]  mute,
`endif
  output logic [15:0] sample,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_FETCH, S_WAIT, S_NEXT, S_MIX
  } state_t;

  state_t      state;
  logic [1:0]  ch;
  logic        tick_pend;

  logic [7:0]  start_lo [4];
  logic [7:0]  start_hi [4];
  logic [7:0]  end_lo   [4];
  logic [7:0]  end_hi   [4];
  logic [7:0]  rate     [4];
  logic [7:0]  vol      [4];

  logic [ROM_AW-1:0] pos [4];
  logic [7:0]  cnt [4];
  logic [7:0]  cur [4];
  logic [3:0]  playing;
  logic [3:0]  fetch_pend;

  logic [ROM_AW-1:0] start_addr [4];
  logic [ROM_AW-1:0] end_addr   [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      start_addr[i] = ROM_AW'({start_hi[i], start_lo[i], 4'h0});
      end_addr[i]   = ROM_AW'({end_hi[i], end_lo[i], 4'h0});
    end
  end

  // Channels allowed into the mix this build.
  logic [3:0] mix_en;
`ifdef GA20_CH_MUTE_EN
  assign mix_en = playing & ~mute;
`else
  assign mix_en = playing;
`endif

  logic signed [16:0] prod [4];
  logic signed [17:0] mix_sum;
  logic signed [17:0] mix_shift;
  logic [15:0]        mix_sat;

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < 4; i++) begin
      // Re-centre the unsigned byte around 0x80, scale by unsigned volume.
      prod[i] = 17'($signed(cur[i] ^ 8'h80)) * 17'($signed({1'b0, vol[i]}));
      if (mix_en[i]) mix_sum = mix_sum + {prod[i][16], prod[i]};
    end
    mix_shift = mix_sum >>> OUT_SHIFT;
    if (mix_shift > 18'sd32767)       mix_sat = 16'h7FFF;
    else if (mix_shift < -18'sd32768) mix_sat = 16'h8000;
    else                              mix_sat = mix_shift[15:0];
  end

  // A tick waiting in tick_pend counts as busy, so busy does not dip in the
  // single IDLE cycle between back-to-back ticks.
  assign busy = (state != S_IDLE) || tick_pend;

  always_comb begin
    dout = 8'h00;
    if (addr[2:0] == 3'd7) dout = {7'b0, playing[addr[4:3]]};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= S_IDLE;
      ch           <= 2'd0;
      tick_pend    <= 1'b0;
      rom.rom_req  <= 1'b0;
      rom.rom_addr <= '0;
      sample       <= 16'h0000;
      playing      <= 4'h0;
      fetch_pend   <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        start_lo[i] <= 8'h00;
        start_hi[i] <= 8'h00;
        end_lo[i]   <= 8'h00;
        end_hi[i]   <= 8'h00;
        rate[i]     <= 8'h00;
        vol[i]      <= 8'h00;
        pos[i]      <= '0;
        cnt[i]      <= 8'h00;
        cur[i]      <= 8'h80;
      end
    end else begin
      // One-deep tick queue: extra ce pulses while one is queued are lost.
      if (state != S_IDLE && ce) tick_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (tick_pend || ce) begin
            state     <= S_STEP;
            ch        <= 2'd0;
            tick_pend <= tick_pend & ce;
          end
        end

        S_STEP: begin
          state <= S_NEXT;
          if (playing[ch]) begin
            if (fetch_pend[ch]) begin
              // First tick after key-on plays the start byte itself;
              // the rate counter starts running on the following tick.
              state <= S_FETCH;
            end else if (cnt[ch] == 8'hFF) begin
              cnt[ch]        <= rate[ch];
              pos[ch]        <= pos[ch] + 1'b1;
              fetch_pend[ch] <= 1'b1;
              state          <= S_FETCH;
            end else begin
              cnt[ch] <= cnt[ch] + 8'd1;
            end
          end
        end

        S_FETCH: begin
          // Re-check: a key-off written during STEP cancels the fetch.
          if (playing[ch] && fetch_pend[ch]) begin
            rom.rom_req  <= 1'b1;
            rom.rom_addr <= pos[ch];
            state        <= S_WAIT;
          end else begin
            state <= S_NEXT;
          end
        end

        S_WAIT: begin
          if (rom.rom_ack) begin
            rom.rom_req    <= 1'b0;
            fetch_pend[ch] <= 1'b0;
            if (rom.rom_data == 8'h00 || pos[ch] >= end_addr[ch]) begin
              playing[ch] <= 1'b0;
              cur[ch]     <= 8'h80;
            end else begin
              cur[ch] <= rom.rom_data;
            end
            state <= S_NEXT;
          end
        end

        S_NEXT: begin
          if (ch == 2'd3) begin
            state <= S_MIX;
          end else begin
            ch    <= ch + 2'd1;
            state <= S_STEP;
          end
        end

        S_MIX: begin
          sample <= mix_sat;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase

      // Register writes come last so a key-on overrides a same-cycle stop.
      if (cs && wr) begin
        case (addr[2:0])
          3'd0: start_lo[addr[4:3]] <= din;
          3'd1: start_hi[addr[4:3]] <= din;
          3'd2: end_lo[addr[4:3]]   <= din;
          3'd3: end_hi[addr[4:3]]   <= din;
          3'd4: rate[addr[4:3]]     <= din;
          3'd5: vol[addr[4:3]]      <= din;
          3'd6: begin
            if (din[1]) begin
              pos[addr[4:3]]        <= start_addr[addr[4:3]];
              cnt[addr[4:3]]        <= rate[addr[4:3]];
              playing[addr[4:3]]    <= 1'b1;
              fetch_pend[addr[4:3]] <= 1'b1;
            end else begin
              playing[addr[4:3]] <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ga20_pcm.sv
`timescale 1ns/1ps
module tb_ga20_pcm;

  localparam int TB_SHIFT = 0;

  // ---------------- clock / reset ----------------
  logic        clk_sys;
  logic        reset;
  logic        ce;
  logic        cs;
  logic        wr;
  logic [4:0]  addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [15:0] sample;
  logic        busy;

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  ga20_pcm_if #(.ROM_AW(20)) rom_if ();

  ga20_pcm #(.ROM_AW(20), .OUT_SHIFT(TB_SHIFT)) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .ce     (ce),
    .cs     (cs),
    .wr     (wr),
    .addr   (addr),
    .din    (din),
    .dout   (dout),
    .rom    (rom_if),
    .sample (sample),
    .busy   (busy)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [19:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- ROM model ----------------
  logic [7:0] rom_mem [int];
  int ack_delay = 0;

  function automatic logic [7:0] rom_byte(input logic [19:0] a);
    if (rom_mem.exists(int'(a))) return rom_mem[int'(a)];
    return (a[7:0] ^ a[15:8] ^ 8'h5A) | 8'h01;
  endfunction

  // ROM responder: checks each request against the expected address queue,
  // holds it for ack_delay cycles, then pulses ack with data.
  initial begin : rom_responder
    logic [19:0] a;
    bit          hit_reset;
    rom_if.rom_ack  = 1'b0;
    rom_if.rom_data = 8'h00;
    forever begin
      @(posedge clk_sys); #1;
      if (rom_if.rom_req === 1'b1) begin
        a = rom_if.rom_addr;
        hit_reset = 1'b0;
        check("fetch_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("fetch_addr", a, exp_q.pop_front());
        for (int d = 0; d < ack_delay; d++) begin
          @(posedge clk_sys); #1;
          if (reset) hit_reset = 1'b1;
          if (!hit_reset) begin
            check("req_held", rom_if.rom_req, 1);
            check("addr_stable", rom_if.rom_addr, a);
          end
        end
        rom_if.rom_ack  = 1'b1;
        rom_if.rom_data = rom_byte(a);
        @(posedge clk_sys); #1;
        rom_if.rom_ack  = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [19:0] m_start [4];
  logic [19:0] m_end   [4];
  logic [7:0]  m_rate  [4];
  logic [7:0]  m_vol   [4];
  logic [7:0]  m_cur   [4];
  bit          m_play  [4];
  int          m_k     [4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_start[i] = 0; m_end[i] = 0; m_rate[i] = 0; m_vol[i] = 0;
      m_cur[i] = 8'h80; m_play[i] = 0; m_k[i] = 0;
    end
    exp_q.delete();
  endtask

  // One tick: channel plays its start byte on the first tick after key-on,
  // then moves one byte every (256 - rate) ticks.
  task automatic model_tick();
    int p;
    logic [19:0] a;
    logic [7:0]  b;
    for (int c = 0; c < 4; c++) begin
      if (m_play[c]) begin
        p = 256 - int'(m_rate[c]);
        if (m_k[c] == 0 || (m_k[c] % p) == 0) begin
          a = m_start[c] + 20'(m_k[c] / p);
          exp_q.push_back(a);
          b = rom_byte(a);
          if (b == 8'h00 || a >= m_end[c]) begin
            m_play[c] = 0;
            m_cur[c]  = 8'h80;
          end else begin
            m_cur[c] = b;
          end
        end
        m_k[c]++;
      end
    end
  endtask

  function automatic logic [15:0] exp_sample();
    int s;
    s = 0;
    for (int c = 0; c < 4; c++)
      if (m_play[c]) s += (int'(m_cur[c]) - 128) * int'(m_vol[c]);
    s = s >>> TB_SHIFT;
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wr_reg(input int c, input int r, input logic [7:0] v);
    @(posedge clk_sys); #1;
    cs = 1'b1; wr = 1'b1; addr = 5'(c * 8 + r); din = v;
    @(posedge clk_sys); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_check(input int c, input int r, input logic [7:0] exp, input string tag);
    @(posedge clk_sys); #1;
    addr = 5'(c * 8 + r);
    #1;
    check(tag, dout, exp);
  endtask

  task automatic keyon(input int c, input logic [15:0] st, input logic [15:0] en,
                       input logic [7:0] rt, input logic [7:0] vl);
    wr_reg(c, 0, st[7:0]);
    wr_reg(c, 1, st[15:8]);
    wr_reg(c, 2, en[7:0]);
    wr_reg(c, 3, en[15:8]);
    wr_reg(c, 4, rt);
    wr_reg(c, 5, vl);
    wr_reg(c, 6, 8'h02);
    m_start[c] = {st, 4'h0};
    m_end[c]   = {en, 4'h0};
    m_rate[c]  = rt;
    m_vol[c]   = vl;
    m_play[c]  = 1;
    m_k[c]     = 0;
  endtask

  task automatic keyoff(input int c);
    wr_reg(c, 6, 8'h00);
    m_play[c] = 0;
  endtask

  task automatic pulse_ce();
    @(posedge clk_sys); #1; ce = 1'b1;
    @(posedge clk_sys); #1; ce = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (rom_if.rom_req !== 1'b1 && n < 100) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check(tag, rom_if.rom_req, 1);
  endtask

  task automatic do_tick(input string tag);
    model_tick();
    pulse_ce();
    wait_idle({tag, "_idle"});
    check(tag, sample, exp_sample());
    check({tag, "_fetches"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int busy_zero;
    int fetched;
    logic [15:0] st;

    reset = 1'b1; ce = 1'b0; cs = 1'b0; wr = 1'b0; addr = 5'd0; din = 8'h00;
    model_reset();
    rom_mem[32'h00100] = 8'hC0; rom_mem[32'h00101] = 8'hC0;
    rom_mem[32'h00102] = 8'hC0; rom_mem[32'h00103] = 8'h00;
    for (int c = 0; c < 4; c++) begin
      rom_mem[32'h01000 + c * 32'h100] = 8'hFF;
      rom_mem[32'h01001 + c * 32'h100] = 8'h01;
    end
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;

    // Reset state
    check("rst_sample", sample, 16'h0000);
    check("rst_rom_req", rom_if.rom_req, 0);
    check("rst_busy", busy, 0);
    for (int c = 0; c < 4; c++) rd_check(c, 7, 8'h00, "rst_status");
    rd_check(0, 0, 8'h00, "rst_read_reg0");

    // Channel 0, rate 0xFF: one byte per tick from 0x00100
    keyon(0, 16'h0010, 16'h0020, 8'hFF, 8'hFF);
    rd_check(0, 7, 8'h01, "keyon_status");
    do_tick("r255_t1");
    check("r255_value", sample, 16'h3FC0);
    do_tick("r255_t2");
    do_tick("r255_t3");
    rd_check(0, 7, 8'h01, "r255_status");
    rd_check(0, 6, 8'h00, "read_reg6_zero");

    // Rate 0xFE: one byte every second tick, zero byte at 0x00103 stops
    keyon(0, 16'h0010, 16'h0020, 8'hFE, 8'hFF);
    for (int t = 0; t < 7; t++) do_tick("r254");
    check("r254_stop_sample", sample, 16'h0000);
    rd_check(0, 7, 8'h00, "r254_stop_status");

    // Saturation with all four channels at full volume
    for (int c = 0; c < 4; c++) keyon(c, 16'(16'h0100 + c * 16'h10), 16'h0200, 8'hFF, 8'hFF);
    do_tick("sat_pos");
    check("sat_pos_value", sample, 16'h7FFF);
    do_tick("sat_neg");
    check("sat_neg_value", sample, 16'h8000);
    for (int c = 0; c < 4; c++) keyoff(c);
    do_tick("all_off");
    for (int c = 0; c < 4; c++) rd_check(c, 7, 8'h00, "all_off_status");

    // ce every 4 cycles with slow ROM: at most one tick queued
    keyon(0, 16'h2000, 16'h2100, 8'hFF, 8'h10);
    ack_delay = 20;
    for (int i = 0; i < 21; i++) exp_q.push_back(20'h20000 + 20'(i));
    busy_zero = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_sys); #1 ce = 1'b1;
      @(posedge clk_sys); #1 ce = 1'b0;
      if (!busy) busy_zero++;
      repeat (2) begin
        @(posedge clk_sys); #1;
        if (!busy) busy_zero++;
      end
    end
    check("burst_busy_held", busy_zero, 0);
    wait_idle("burst_idle");
    fetched = 21 - exp_q.size();
    check("burst_fetch_bound", 32'(fetched >= 4 && fetched <= 10), 1);
    exp_q.delete();
    m_cur[0] = rom_byte(20'h20000 + 20'(fetched - 1));
    check("burst_sample", sample, exp_sample());
    keyoff(0);
    ack_delay = 0;

    // Reset while waiting on the ROM; the late ack must be ignored
    keyon(1, 16'h3000, 16'h3100, 8'hFF, 8'h40);
    ack_delay = 20;
    model_tick();
    pulse_ce();
    wait_req("midfetch_req");
    repeat (5) @(posedge clk_sys);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
    model_reset();
    check("midrst_rom_req", rom_if.rom_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sample", sample, 16'h0000);
    rd_check(1, 7, 8'h00, "midrst_status");
    repeat (25) @(posedge clk_sys);
    #1;
    check("lateack_rom_req", rom_if.rom_req, 0);
    check("lateack_busy", busy, 0);
    rd_check(1, 7, 8'h00, "lateack_status");
    ack_delay = 0;
    do_tick("post_reset_tick");

    // Key-on in the same cycle as an end-of-sample stop
    keyon(2, 16'h0400, 16'h0400, 8'hFF, 8'h80);
    ack_delay = 4;
    model_tick();
    pulse_ce();
    wait_req("race_req");
    repeat (4) @(posedge clk_sys);
    #1;
    cs = 1'b1; wr = 1'b1; addr = 5'(2 * 8 + 6); din = 8'h02;
    @(posedge clk_sys); #1;
    cs = 1'b0; wr = 1'b0;
    m_play[2] = 1; m_k[2] = 0; m_cur[2] = 8'h80;
    wait_idle("race_idle");
    check("race_sample", sample, exp_sample());
    rd_check(2, 7, 8'h01, "race_keyon_wins");
    ack_delay = 0;
    do_tick("race_restart");
    rd_check(2, 7, 8'h00, "race_restart_stop");

    // Randomized playback against the model
    for (int round = 0; round < 3; round++) begin
      for (int c = 0; c < 4; c++) begin
        st = 16'($urandom_range(0, 16'hEFFF));
        keyon(c, st, 16'(st + 16'($urandom_range(1, 3))),
              8'(8'hFF - $urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      end
      for (int t = 0; t < 20; t++) begin
        ack_delay = $urandom_range(0, 3);
        do_tick("rand_tick");
      end
      for (int c = 0; c < 4; c++) rd_check(c, 7, 8'(m_play[c]), "rand_status");
      for (int c = 0; c < 4; c++) keyoff(c);
    end
    ack_delay = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
